// File: rtl/score_pkg.sv
// Shared definitions for the match score counter: BCD limit, FSM state type
// and the single-digit BCD increment helper.
package score_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic {
    ST_ARMED = 1'b0,
    ST_HELD  = 1'b1
  } state_e;

  // Returns {cout, digit'}: a 9 with carry-in wraps to 0 and carries out.
  function automatic logic [4:0] bcd_inc(input logic [3:0] digit, input logic cin);
    logic [4:0] r;
    if (!cin) begin
      r = {1'b0, digit};
    end else if (digit >= BCD_MAX) begin
      r = {1'b1, 4'd0};
    end else begin
      r = {1'b0, digit + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the score: 4-bit register with ripple carry in/out and
// synchronous clear. The carry out is combinational from the register and
// carry in, so a chain of digits ripples within one clock.
module bcd_digit
  import score_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       cin_i,
  output logic [3:0] digit_o,
  output logic       cout_o
);

  logic [3:0] digit_q, digit_d;
  logic [4:0] inc;

  // Next digit value: clear wins, otherwise BCD increment on carry-in.
  always_comb begin
    inc     = bcd_inc(digit_q, cin_i);
    digit_d = clr_i ? 4'd0 : inc[3:0];
  end

  // Digit register with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) digit_q <= 4'd0;
    else         digit_q <= digit_d;
  end

  assign digit_o = digit_q;
  assign cout_o  = inc[4];

endmodule

// File: rtl/match_score_counter.sv
// Match score counter: counts switch-versus-memory match episodes (one count
// per episode) into a packed BCD score with a match pulse and sticky overflow.
// Optional build macro: SCORE_SATURATE_EN -- score saturates at all-9s instead
// of wrapping to 0.
//
// There is no request/response handshake: iValid is a pure qualifier. Operands
// are compared only on cycles where iValid is high; iValid low is a no-op.
module match_score_counter
  import score_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 2
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iValid,
  input  logic                  iClr,
  input  logic [DATA_W-1:0]     mem_value,
  input  logic [DATA_W-1:0]     iSW,
  output logic [4*DIGITS-1:0]   oDigits,
  output logic                  oMatch,
  output logic                  oOvf,
  output logic                  oArmed
);

  logic [1:0]    rst_sync_q;
  logic          rst_n;
  state_e        state_q, state_d;
  logic          eq, count;
  logic          inc_en, ovf_set;
  logic          match_q, ovf_q;
  logic [DIGITS:0] carry;

  // Reset synchroniser: asserts immediately, releases two edges later.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) rst_sync_q <= 2'b00;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign eq = (mem_value == iSW);

  // Episode FSM: count once on an armed match, re-arm on a qualified mismatch.
  always_comb begin
    state_d = state_q;
    count   = 1'b0;
    case (state_q)
      ST_ARMED: if (iValid && eq) begin
        count   = 1'b1;
        state_d = ST_HELD;
      end
      ST_HELD: if (iValid && !eq) state_d = ST_ARMED;
      default: state_d = ST_ARMED;
    endcase
    if (iClr) begin
      state_d = ST_ARMED;
      count   = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge iClk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ARMED;
    else        state_q <= state_d;
  end

`ifdef SCORE_SATURATE_EN
  logic all9;

  // Saturation: at all-9s a counted match only flags overflow.
  always_comb begin
    all9 = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (oDigits[4*k +: 4] != BCD_MAX) all9 = 1'b0;
    end
    inc_en  = count && !all9;
    ovf_set = (count && all9) || carry[DIGITS];
  end
`else
  // Wrap: carry out of the top digit means all-9s rolled to 0.
  always_comb begin
    inc_en  = count;
    ovf_set = carry[DIGITS];
  end
`endif

  assign carry[0] = inc_en;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk_i   (iClk),
      .rst_ni  (rst_n),
      .clr_i   (iClr),
      .cin_i   (carry[k]),
      .digit_o (oDigits[4*k +: 4]),
      .cout_o  (carry[k+1])
    );
  end

  // Match pulse and sticky overflow registers.
  always_ff @(posedge iClk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      match_q <= count;
      if (iClr)         ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
    end
  end

  assign oMatch = match_q;
  assign oOvf   = ovf_q;
  assign oArmed = (state_q == ST_ARMED);

endmodule

// File: tb/tb_match_score_counter.sv
// Bench for match_score_counter: one 8-bit/2-digit instance and one
// 16-bit/4-digit instance, checked every cycle against an integer-score model.
module tb_match_score_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_a = 1'b0, clr_a = 1'b0;
  logic [7:0]  mem_a = '0, sw_a = '0;
  logic [7:0]  dig_a;
  logic        match_a, ovf_a, armed_a;
  logic        valid_b = 1'b0, clr_b = 1'b0;
  logic [15:0] mem_b = '0, sw_b = '0;
  logic [15:0] dig_b;
  logic        match_b, ovf_b, armed_b;

  int checks = 0;
  int failures = 0;

  // model state per instance: integer score, armed flag, sticky overflow
  int  m_score [2];
  bit  m_armed [2];
  bit  m_ovf   [2];
  bit  m_match [2];
  logic [31:0] exp_q[$];

  // clock/reset block
  always #5 clk = ~clk;

  match_score_counter #(.DATA_W(8), .DIGITS(2)) u_dut_a (
    .iClk(clk), .iRst(rst), .iValid(valid_a), .iClr(clr_a),
    .mem_value(mem_a), .iSW(sw_a), .oDigits(dig_a),
    .oMatch(match_a), .oOvf(ovf_a), .oArmed(armed_a)
  );

  match_score_counter #(.DATA_W(16), .DIGITS(4)) u_dut_b (
    .iClk(clk), .iRst(rst), .iValid(valid_b), .iClr(clr_b),
    .mem_value(mem_b), .iSW(sw_b), .oDigits(dig_b),
    .oMatch(match_b), .oOvf(ovf_b), .oArmed(armed_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int val, input int digits);
    logic [31:0] r;
    int v;
    r = '0;
    v = val;
    for (int k = 0; k < digits; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int max_score(input int id);
    return (id == 0) ? 99 : 9999;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_score[i] = 0; m_armed[i] = 1'b1; m_ovf[i] = 1'b0; m_match[i] = 1'b0;
    end
  endtask

  // Reference rules: one count per match episode, decimal score modulo
  // 10^DIGITS (or held at the maximum when saturating).
  task automatic model_step(input int id, input bit v, input bit c, input bit eq);
    if (c) begin
      m_score[id] = 0; m_ovf[id] = 1'b0; m_armed[id] = 1'b1; m_match[id] = 1'b0;
    end else if (m_armed[id] && v && eq) begin
      m_match[id] = 1'b1;
      m_armed[id] = 1'b0;
      if (m_score[id] == max_score(id)) begin
        m_ovf[id] = 1'b1;
`ifdef SCORE_SATURATE_EN
        m_score[id] = max_score(id);
`else
        m_score[id] = 0;
`endif
      end else begin
        m_score[id] = m_score[id] + 1;
      end
    end else begin
      m_match[id] = 1'b0;
      if (!m_armed[id] && v && !eq) m_armed[id] = 1'b1;
    end
  endtask

  // driver task: one clock of stimulus to instance id, then model and compare
  task automatic step(input int id, input bit v, input bit c,
                      input logic [15:0] m, input logic [15:0] s);
    bit eq;
    valid_a = 1'b0; clr_a = 1'b0; valid_b = 1'b0; clr_b = 1'b0;
    if (id == 0) begin
      valid_a = v; clr_a = c; mem_a = m[7:0]; sw_a = s[7:0];
      eq = (m[7:0] == s[7:0]);
    end else begin
      valid_b = v; clr_b = c; mem_b = m; sw_b = s;
      eq = (m == s);
    end
    @(posedge clk);
    #1;
    model_step(id, v, c, eq);
    exp_q.push_back(to_bcd(m_score[id], (id == 0) ? 2 : 4));
    if (id == 0) begin
      check("digits_a", {24'd0, dig_a}, exp_q.pop_front());
      check("match_a", {31'd0, match_a}, {31'd0, m_match[0]});
      check("ovf_a", {31'd0, ovf_a}, {31'd0, m_ovf[0]});
      check("armed_a", {31'd0, armed_a}, {31'd0, m_armed[0]});
    end else begin
      check("digits_b", {16'd0, dig_b}, exp_q.pop_front());
      check("match_b", {31'd0, match_b}, {31'd0, m_match[1]});
      check("ovf_b", {31'd0, ovf_b}, {31'd0, m_ovf[1]});
      check("armed_b", {31'd0, armed_b}, {31'd0, m_armed[1]});
    end
  endtask

  // one match episode: a qualified match followed by a qualified mismatch
  task automatic episode(input int id);
    logic [15:0] r;
    r = 16'($urandom);
    step(id, 1'b1, 1'b0, r, r);
    step(id, 1'b1, 1'b0, r, r ^ 16'h0001);
  endtask

  task automatic idle(input int id, input int n);
    for (int i = 0; i < n; i++) step(id, 1'b0, 1'b0, 16'h0, 16'h1);
  endtask

  int pulses;
  logic [15:0] r;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(0, 3);
    check("reset_digits", {24'd0, dig_a}, 32'h0);
    check("reset_armed", {31'd0, armed_a}, 32'h1);

    // hold match: 10 cycles of A5 == A5 counts once
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1'b1, 1'b0, 16'h00A5, 16'h00A5);
      if (match_a) pulses++;
    end
    check("hold_pulses", pulses, 1);
    check("hold_digits", {24'd0, dig_a}, 32'h01);

    // re-arm: 12 alternating match/mismatch episodes
    step(0, 1'b0, 1'b1, 16'h0, 16'h0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      r = 16'($urandom);
      step(0, 1'b1, 1'b0, r, r);
      if (match_a) pulses++;
      step(0, 1'b1, 1'b0, r, ~r);
    end
    check("rearm_pulses", pulses, 12);
    check("rearm_digits", {24'd0, dig_a}, 32'h12);
    // held state: unqualified mismatch must not re-arm, unqualified match not count
    step(0, 1'b1, 1'b0, 16'h5, 16'h5);
    step(0, 1'b0, 1'b0, 16'h5, 16'h6);
    step(0, 1'b0, 1'b0, 16'h5, 16'h5);
    check("noqual_digits", {24'd0, dig_a}, 32'h13);

    // carry 09 -> 10, then 99 -> wrap/saturate
    step(0, 1'b0, 1'b1, 16'h0, 16'h0);
    for (int i = 0; i < 10; i++) episode(0);
    check("carry_digits", {24'd0, dig_a}, 32'h10);
    for (int i = 0; i < 89; i++) episode(0);
    check("max_digits", {24'd0, dig_a}, 32'h99);
    episode(0);
    check("ovf_after_max", {31'd0, ovf_a}, 32'h1);
    episode(0);

    // clear priority over a counted match on the same edge
    step(0, 1'b1, 1'b1, 16'h33, 16'h33);
    check("clr_digits", {24'd0, dig_a}, 32'h0);
    check("clr_armed", {31'd0, armed_a}, 32'h1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = 16'($urandom);
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, r,
           ($urandom_range(0, 1) == 1) ? r : 16'($urandom));
    end

    // asynchronous reset mid-count at score 37
    step(0, 1'b0, 1'b1, 16'h0, 16'h0);
    for (int i = 0; i < 37; i++) episode(0);
    check("pre_reset_digits", {24'd0, dig_a}, 32'h37);
    #2 rst = 1'b0;
    #1;
    check("async_digits", {24'd0, dig_a}, 32'h0);
    check("async_armed", {31'd0, armed_a}, 32'h1);
    check("async_match", {31'd0, match_a}, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    idle(0, 3);

    // 16-bit / 4-digit: 1234 episodes, mismatches differ only in bit 15
    for (int i = 0; i < 1234; i++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 7) == 0) step(1, 1'b1, 1'b0, r, r ^ 16'h8000);
      step(1, 1'b1, 1'b0, r, r);
      step(1, 1'b1, 1'b0, r, r ^ 16'h8000);
    end
    check("wide_digits", {16'd0, dig_b}, 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/match_score_counter.md
# match_score_counter

Parametrised successor to the switch-versus-memory match scorer. Compares a memory-sourced value against the switch input on qualified cycles and counts match events in a DIGITS-wide packed BCD score for the seven-segment display path. Each match episode counts once, not once per clock. Adds sync clear, configurable width/digit count, a match pulse and sticky overflow.

## Interface
- DATA_W, 8, width of compared operands
- DIGITS, 2, number of BCD score digits (1..8); digit 0 = units
- iClk  in  1  system clock, rising edge
- iRst  in  1  asynchronous active-low reset
- iValid  in  1  compare qualifier; operands sampled only when high
- iClr  in  1  synchronous score clear, priority over counting
- mem_value  in  DATA_W  value read from memory
- iSW  in  DATA_W  switch value
- oDigits  out  4*DIGITS  packed BCD score, digit k at [4k+3:4k]
- oMatch  out  1  one-cycle pulse per counted match
- oOvf  out  1  sticky: score passed all-9s
- oArmed  out  1  high when the next match will count

## Operation
- Match condition: iValid && (mem_value == iSW), full DATA_W equality.
- Two-state FSM:
  - ARMED (reset state): match -> increment score, pulse oMatch, go HELD.
  - HELD: ignore matches. iValid && mismatch -> ARMED. iValid low -> stay HELD.
- Increment is BCD ripple. Digit 0 +1. A digit at 9 with carry-in -> 0, carry-out 1. Otherwise digit+1, carry-out 0. Digits never hold 10..15.
- Carry out of the top digit means all-9s -> 0 (wrap) and sets oOvf. oOvf clears only on reset or iClr.
- iClr: all digits -> 0, oOvf -> 0, FSM -> ARMED, oMatch -> 0. Any same-cycle match is discarded.
- oArmed = (state == ARMED).

## Timing
- Reset (async assert, any time): oDigits all 0, oMatch 0, oOvf 0, FSM ARMED, oArmed 1. Takes effect immediately, mid-increment included. Deassertion is synchronised by the top level.
- Match sampled at edge N -> oDigits updated and oMatch high after edge N, for exactly one cycle.
- oMatch and oDigits change on the same edge. No combinational path from inputs to outputs.
- Back-to-back: match at N, mismatch at N+1, match at N+2 -> two counts. Continuous match for K cycles -> one count.
- Ripple carry settles within one cycle for all DIGITS ≤ 8.

## Configuration
- SCORE_SATURATE_EN defined: at all-9s, further counted matches leave the score at all-9s. oOvf sets on the first such attempt. oMatch still pulses.
- SCORE_SATURATE_EN undefined: all-9s wraps to 0 and sets oOvf (default).

## Structure
- Package score_pkg: BCD_MAX = 4'd9, FSM state typedef {ST_ARMED, ST_HELD}, helper function bcd_inc(digit, cin) returning {cout, digit}.
- Sub-module bcd_digit: one 4-bit BCD register with cin/cout, clear, async reset. Generated DIGITS times and chained by carry.
- Top level holds the comparator, FSM, oMatch register, oOvf register and macro-selected saturation logic.

## Test plan
- Reset mid-count: score 0x37, assert iRst low between edges -> oDigits 0x00, oArmed 1 immediately, no oMatch.
- Hold match: mem_value = iSW = 8'hA5, iValid high for 10 cycles -> oDigits 0x01, single oMatch pulse, oArmed 0.
- Re-arm: alternate match/mismatch 12 times with iValid high -> oDigits 0x12, 12 oMatch pulses. Match with iValid low -> no count, no re-arm.
- Carry: score 0x09, one match -> 0x10. Score 0x99 (DIGITS=2), one match -> 0x00, oOvf 1. With SCORE_SATURATE_EN -> stays 0x99, oOvf 1, oMatch pulses.
- Clear priority: iClr and a counted match on the same edge -> oDigits 0x00, oOvf 0, oMatch 0, oArmed 1.
- Parametrisation: DATA_W=16, DIGITS=4, 1234 match episodes -> oDigits 16'h1234. Operands differing only in bit 15 never count.
